// File: rtl/xor_unit_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : xor_unit_arbiter                                         |
// | Description : Round-robin sequencer sharing one registered XOR unit    |
// |               between N requesters, valid/ready result return.         |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module xor_unit_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] a_in,
  input  logic [N*WIDTH-1:0] b_in,
  output logic [N-1:0]       gnt,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic [ID_W-1:0]    res_id,
  output logic [CNT_W-1:0]   op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q;
  logic [ID_W-1:0]    rr_q;
  logic [WIDTH-1:0]   a_lat_q;
  logic [WIDTH-1:0]   b_lat_q;
  logic [N-1:0]       gnt_q;
  logic               busy_q;
  logic               res_valid_q;
  logic [WIDTH-1:0]   res_data_q;
  logic [ID_W-1:0]    res_id_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               win_found_d;
  logic [ID_W-1:0]    win_idx_d;

  // Scan from the highest offset down so the nearest request above rr_q wins.
  always_comb begin
    int idx;
    idx         = 0;
    win_found_d = 1'b0;
    win_idx_d   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = (int'(rr_q) + off) % N;
      if (req[idx]) begin
        win_found_d = 1'b1;
        win_idx_d   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      a_lat_q     <= '0;
      b_lat_q     <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      cnt_q       <= '0;
    end else begin
      gnt_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found_d) begin
            a_lat_q          <= a_in[win_idx_d*WIDTH +: WIDTH];
            b_lat_q          <= b_in[win_idx_d*WIDTH +: WIDTH];
            res_id_q         <= win_idx_d;
            gnt_q[win_idx_d] <= 1'b1;
            busy_q           <= 1'b1;
            state_q          <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_data_q  <= a_lat_q ^ b_lat_q;
          res_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            cnt_q       <= cnt_q + CNT_W'(1);
            // Priority rotates only on completion, to the requester after the one served.
            if (res_id_q == ID_W'(N - 1)) begin
              rr_q <= '0;
            end else begin
              rr_q <= res_id_q + ID_W'(1);
            end
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign op_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_unit_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_xor_unit_arbiter                                      |
// | Description : Scoreboard bench for xor_unit_arbiter (CNT_W = 3).       |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_xor_unit_arbiter;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 3;

  logic               clk;
  logic               rst;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] a_in;
  logic [N*WIDTH-1:0] b_in;
  logic [N-1:0]       gnt;
  logic               busy;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH-1:0]   res_data;
  logic [ID_W-1:0]    res_id;
  logic [CNT_W-1:0]   op_count;

  xor_unit_arbiter #(
    .WIDTH(WIDTH), .N(N), .ID_W(ID_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
  } res_t;

  res_t        rq[$];
  logic [N-1:0] gq[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [CNT_W-1:0] sb_cnt;

  // Hand-computed a ^ b per requester: 3C^FF, 5A^0F, A5^0F, F0^0F.
  logic [WIDTH-1:0] exp_x [N] = '{8'hC3, 8'h55, 8'hAA, 8'hFF};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic push_op(input int id);
    res_t it;
    sb_cnt  = sb_cnt + 3'd1;
    it.id   = ID_W'(id);
    it.data = exp_x[id];
    it.cnt  = sb_cnt;
    gq.push_back(N'(1 << id));
    rq.push_back(it);
  endtask

  task automatic wait_gnt(output int t);
    int i;
    t = -1;
    i = 0;
    while (t < 0 && i < 30) begin
      @(negedge clk);
      if ((|gnt) === 1'b1) t = cyc;
      i++;
    end
    if (t < 0) timeout("wait_gnt");
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((rq.size() != 0 || gq.size() != 0) && i < 60) begin
      @(negedge clk);
      i++;
    end
    if (rq.size() != 0 || gq.size() != 0) timeout("drain");
    repeat (2) @(negedge clk);
  endtask

  task automatic single_op(input int id);
    int t;
    push_op(id);
    req = N'(1 << id);
    wait_gnt(t);
    req = '0;
    @(negedge clk);
    chk("latency_valid", res_valid, 1);
    drain();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst    = 1'b0;
    sb_cnt = '0;
  endtask

  // Grant monitor: every cycle with a grant consumes one expected grant.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if ((|gnt) === 1'b1) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", gnt, 0);
        end else begin
          chk("gnt", gnt, gq.pop_front());
        end
      end
    end
  end

  // Result monitor: compares on each accepted result, then the counter after the edge.
  initial begin
    res_t it;
    forever begin
      @(negedge clk);
      #1;
      if ((res_valid && res_ready) === 1'b1) begin
        if (rq.size() == 0) begin
          chk("res_unexpected", res_valid, 0);
        end else begin
          it = rq.pop_front();
          chk("res_data", res_data, it.data);
          chk("res_id", res_id, it.id);
          @(posedge clk);
          #1;
          chk("op_count", op_count, it.cnt);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int prev;
    sb_cnt    = '0;
    rst       = 1'b1;
    req       = 4'b1111;
    res_ready = 1'b0;
    a_in      = {8'hF0, 8'hA5, 8'h5A, 8'h3C};
    b_in      = {8'h0F, 8'h0F, 8'h0F, 8'hFF};

    // Reset with all requests asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_count", op_count, 0);
    chk("rst_busy", busy, 0);
    req = '0;
    rst = 1'b0;

    // Single request from requester 2
    res_ready = 1'b1;
    single_op(2);

    // Fairness from a fresh reset: 0,1,2,3,0, three cycles apart
    pulse_reset();
    for (int k = 0; k < 5; k++) push_op(k % N);
    req  = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(t);
      if (k > 0 && t >= 0) chk("grant_spacing", t - prev, 3);
      prev = t;
    end
    req = '0;
    drain();

    // Backpressure: rr now 1, result held five cycles, then next grant to 2
    res_ready = 1'b0;
    push_op(1);
    push_op(2);
    req = 4'b1111;
    wait_gnt(t);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold", {gnt, res_valid, res_data, res_id}, {4'b0000, 1'b1, 8'h55, 2'd1});
    end
    res_ready = 1'b1;
    wait_gnt(t);
    req = '0;
    drain();

    // Reset mid-operation: rr now 3
    res_ready = 1'b0;
    gq.push_back(4'b1000);
    req = 4'b1111;
    wait_gnt(t);
    @(negedge clk);
    chk("mid_valid", res_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", res_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", op_count, 0);
    chk("midrst_gnt", gnt, 0);
    sb_cnt = '0;
    push_op(0);
    rst       = 1'b0;
    res_ready = 1'b1;
    wait_gnt(t);
    req = '0;
    drain();

    // Counter wrap with a 3-bit counter: 1..7,0,1
    pulse_reset();
    for (int k = 0; k < 9; k++) single_op(0);
    chk("wrap_final", op_count, 1);

    chk("queues_empty", rq.size() + gq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
